array_reduction_engine: RTL and testbench

Parametrised reduction stage that sits after the multi-array systolic pipeline and collapses its NUM_ARRAYS tile-matrix results into one TILE_SIZE-wide vector per output beat. MAC mode (3'b000) accumulates row-reduced results of the last array over a programmable number of beats. OUTER mode (3'b011) sums row-reduced results of all arrays every beat. It adds valid/ready flow control, a synchronous clear, width-growth-safe arithmetic and optional output saturation.

---
 rtl/reduce_pkg.sv | 16 +
 rtl/row_reducer.sv | 29 ++
 rtl/array_reduction_engine.sv | 203 ++++++++++++++++++++
 tb/tb_array_reduction_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared constants, FSM type and width helper for the array reduction engine.
package reduce_pkg;

    localparam logic [2:0] MODE_MAC   = 3'b000;
    localparam logic [2:0] MODE_OUTER = 3'b011;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_e;

    // Wide enough that row, array and tile-length accumulation can never overflow.
    function automatic int unsigned sum_width(input int unsigned acc_w, input int unsigned tile,
                                              input int unsigned arrays,
                                              input int unsigned max_len);
        return acc_w + $clog2(tile) + $clog2(arrays) + $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/row_reducer.sv
// Combinational TILE_SIZE x TILE_SIZE signed matrix to TILE_SIZE row sums at SUM_W bits.
module row_reducer
    import reduce_pkg::*;
#(
    parameter int unsigned TILE_SIZE = 4,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SUM_W     = 43
) (
    input  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] mat_i,
    output logic [TILE_SIZE*SUM_W-1:0]               row_sum_o
);

    logic signed [SUM_W-1:0] sums [TILE_SIZE];

    always_comb begin
        for (int r = 0; r < TILE_SIZE; r++) begin
            sums[r] = '0;
            for (int c = 0; c < TILE_SIZE; c++) begin
                sums[r] = sums[r]
                        + SUM_W'($signed(mat_i[(r*TILE_SIZE+c)*ACC_WIDTH +: ACC_WIDTH]));
            end
        end
    end

    for (genvar r = 0; r < TILE_SIZE; r++) begin : g_out
        assign row_sum_o[r*SUM_W +: SUM_W] = sums[r];
    end

endmodule

// File: rtl/array_reduction_engine.sv
// Reduces NUM_ARRAYS tile matrices to one vector per output beat (MAC or OUTER mode).
// Define REDUCE_SAT_EN to clamp outputs to OUT_WIDTH instead of wrapping.
module array_reduction_engine
    import reduce_pkg::*;
#(
    parameter int unsigned NUM_ARRAYS   = 4,
    parameter int unsigned TILE_SIZE    = 4,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned OUT_WIDTH    = 32,
    parameter int unsigned MAX_TILE_LEN = 64
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [2:0]                                      mode,
    input  logic [$clog2(MAX_TILE_LEN+1)-1:0]               tile_len,
    input  logic                                            clear,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [NUM_ARRAYS*TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] mat_in,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [TILE_SIZE*OUT_WIDTH-1:0]                  out_vec,
    output logic                                            sat_flag,
    output logic                                            err_mode
);

    localparam int unsigned SUM_W = sum_width(ACC_WIDTH, TILE_SIZE, NUM_ARRAYS, MAX_TILE_LEN);
    localparam int unsigned TL_W  = $clog2(MAX_TILE_LEN + 1);
    localparam int unsigned MAT_W = TILE_SIZE * TILE_SIZE * ACC_WIDTH;
    localparam int unsigned RS_W  = TILE_SIZE * SUM_W;

    logic [NUM_ARRAYS*RS_W-1:0] row_sums;

    for (genvar a = 0; a < NUM_ARRAYS; a++) begin : g_rr
        row_reducer #(
            .TILE_SIZE (TILE_SIZE),
            .ACC_WIDTH (ACC_WIDTH),
            .SUM_W     (SUM_W)
        ) u_row_reducer (
            .mat_i     (mat_in[a*MAT_W +: MAT_W]),
            .row_sum_o (row_sums[a*RS_W +: RS_W])
        );
    end

    logic signed [SUM_W-1:0] outer_sum [TILE_SIZE];
    logic signed [SUM_W-1:0] mac_sum   [TILE_SIZE];

    always_comb begin
        for (int r = 0; r < TILE_SIZE; r++) begin
            outer_sum[r] = '0;
            for (int a = 0; a < NUM_ARRAYS; a++) begin
                outer_sum[r] = outer_sum[r] + $signed(row_sums[(a*TILE_SIZE+r)*SUM_W +: SUM_W]);
            end
            mac_sum[r] = $signed(row_sums[((NUM_ARRAYS-1)*TILE_SIZE+r)*SUM_W +: SUM_W]);
        end
    end

    state_e                  state_q, state_d;
    logic [TL_W-1:0]         cnt_q, cnt_d, len_q, len_d, len_eff;
    logic                    err_q, err_d, rdy_q;
    logic                    s1_valid_q, s1_final_q;
    logic signed [SUM_W-1:0] s1_sum_q [TILE_SIZE];
    logic signed [SUM_W-1:0] acc_q    [TILE_SIZE];
    logic                    out_valid_q, sat_q, sat_d;
    logic [TILE_SIZE*OUT_WIDTH-1:0] out_vec_q, out_vec_d;
    logic [TILE_SIZE-1:0]    sat_elem;
    logic                    accept, s1_adv, beat_load, beat_final, beat_outer;

    // A final beat may only leave stage 1 when the output register is free.
    assign s1_adv   = s1_valid_q & ~clear & (~s1_final_q | ~out_valid_q | out_ready);
    assign in_ready = rdy_q & ~clear & (~s1_valid_q | s1_adv);
    assign accept   = in_valid & in_ready;
    assign len_eff  = (tile_len == '0) ? TL_W'(1) : tile_len;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        beat_load  = 1'b0;
        beat_final = 1'b0;
        beat_outer = 1'b0;
        if (clear) begin
            cnt_d = '0;
            if (state_q != EMIT) state_d = IDLE;
        end else if (accept) begin
            if (state_q == ACCUM) begin
                beat_load = 1'b1;
                if (cnt_q + TL_W'(1) == len_q) begin
                    beat_final = 1'b1;
                    cnt_d      = '0;
                    state_d    = EMIT;
                end else begin
                    cnt_d = cnt_q + TL_W'(1);
                end
            end else if (mode == MODE_OUTER) begin
                beat_load  = 1'b1;
                beat_final = 1'b1;
                beat_outer = 1'b1;
                state_d    = EMIT;
            end else if (mode == MODE_MAC) begin
                beat_load = 1'b1;
                if (len_eff == TL_W'(1)) begin
                    beat_final = 1'b1;
                    state_d    = EMIT;
                end else begin
                    len_d   = len_eff;
                    cnt_d   = TL_W'(1);
                    state_d = ACCUM;
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == EMIT && !s1_valid_q && (!out_valid_q || out_ready)) begin
            state_d = IDLE;
        end
    end

    for (genvar r = 0; r < TILE_SIZE; r++) begin : g_conv
        logic signed [SUM_W-1:0] total;
        assign total = acc_q[r] + s1_sum_q[r];
`ifdef REDUCE_SAT_EN
        if (OUT_WIDTH < SUM_W) begin : g_clamp
            logic [SUM_W-OUT_WIDTH:0] upper;
            assign upper       = total[SUM_W-1:OUT_WIDTH-1];
            assign sat_elem[r] = ~(&upper | ~|upper);
            assign out_vec_d[r*OUT_WIDTH +: OUT_WIDTH] = !sat_elem[r] ? total[OUT_WIDTH-1:0]
                : {total[SUM_W-1], {(OUT_WIDTH-1){~total[SUM_W-1]}}};
        end else begin : g_fit
            assign sat_elem[r] = 1'b0;
            assign out_vec_d[r*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(total);
        end
`else
        assign sat_elem[r] = 1'b0;
        assign out_vec_d[r*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(total);
`endif
    end

    assign sat_d = |sat_elem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_final_q <= 1'b0;
            for (int r = 0; r < TILE_SIZE; r++) s1_sum_q[r] <= '0;
        end else if (clear) begin
            s1_valid_q <= 1'b0;
            s1_final_q <= 1'b0;
            for (int r = 0; r < TILE_SIZE; r++) s1_sum_q[r] <= '0;
        end else if (beat_load) begin
            s1_valid_q <= 1'b1;
            s1_final_q <= beat_final;
            for (int r = 0; r < TILE_SIZE; r++) begin
                s1_sum_q[r] <= beat_outer ? outer_sum[r] : mac_sum[r];
            end
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < TILE_SIZE; r++) acc_q[r] <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            for (int r = 0; r < TILE_SIZE; r++) begin
                if (clear)       acc_q[r] <= '0;
                else if (s1_adv) acc_q[r] <= s1_final_q ? '0 : acc_q[r] + s1_sum_q[r];
            end
            if (s1_adv && s1_final_q) begin
                out_valid_q <= 1'b1;
                out_vec_q   <= out_vec_d;
                sat_q       <= sat_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign sat_flag  = sat_q;
    assign err_mode  = err_q;

endmodule

// File: tb/tb_array_reduction_engine.sv
// Scoreboard bench for array_reduction_engine with a beat-level reference model.
`timescale 1ns/1ps
module tb_array_reduction_engine;

    localparam int NA  = 4;
    localparam int TS  = 4;
    localparam int AW  = 32;
    localparam int OW  = 16;
    localparam int ML  = 64;
    localparam int TLW = $clog2(ML + 1);
    localparam int MW  = NA * TS * TS * AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      mode = 3'b000;
    logic [TLW-1:0]  tile_len = '0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [MW-1:0]   mat_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [TS*OW-1:0] out_vec;
    logic            sat_flag;
    logic            err_mode;

    array_reduction_engine #(
        .NUM_ARRAYS   (NA),
        .TILE_SIZE    (TS),
        .ACC_WIDTH    (AW),
        .OUT_WIDTH    (OW),
        .MAX_TILE_LEN (ML)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .tile_len  (tile_len),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mat_in    (mat_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .sat_flag  (sat_flag),
        .err_mode  (err_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TS*OW-1:0] vec;
        logic             sat;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     rdy_mode = 0;
    bit     mac_open = 0;
    int     mac_len = 0;
    int     mac_cnt = 0;
    longint mac_acc [TS];
    bit     exp_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint rowsum(input int a, input int r);
        longint s = 0;
        for (int c = 0; c < TS; c++) s += longint'($signed(mat_in[((a*TS+r)*TS+c)*AW +: AW]));
        return s;
    endfunction

    function automatic void push_result(input longint v [TS]);
        exp_t   e;
        longint x;
        longint mx = (longint'(1) <<< (OW - 1)) - 1;
        longint mn = -mx - 1;
        e.vec = '0;
        e.sat = 1'b0;
        for (int r = 0; r < TS; r++) begin
            x = v[r];
`ifdef REDUCE_SAT_EN
            if (x > mx) begin
                x = mx;
                e.sat = 1'b1;
            end else if (x < mn) begin
                x = mn;
                e.sat = 1'b1;
            end
`endif
            e.vec[r*OW +: OW] = x[OW-1:0];
        end
        exp_q.push_back(e);
    endfunction

    // Reference behaviour of one accepted beat, straight from the mode rules.
    function automatic void model_accept(input logic [2:0] m, input int len);
        longint v [TS];
        if (mac_open) begin
            for (int r = 0; r < TS; r++) mac_acc[r] += rowsum(NA - 1, r);
            mac_cnt++;
            if (mac_cnt == mac_len) begin
                push_result(mac_acc);
                mac_open = 0;
            end
        end else if (m == 3'b011) begin
            for (int r = 0; r < TS; r++) begin
                v[r] = 0;
                for (int a = 0; a < NA; a++) v[r] += rowsum(a, r);
            end
            push_result(v);
        end else if (m == 3'b000) begin
            mac_len = (len == 0) ? 1 : len;
            for (int r = 0; r < TS; r++) mac_acc[r] = rowsum(NA - 1, r);
            mac_cnt = 1;
            if (mac_len == 1) push_result(mac_acc);
            else mac_open = 1;
        end else begin
            exp_err = 1;
        end
    endfunction

    task automatic send_beat(input logic [2:0] m, input int len);
        int waited = 0;
        mode     = m;
        tile_len = TLW'(len);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                timeout("send_beat");
                in_valid = 1'b0;
                return;
            end
            step();
        end
        model_accept(m, len);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) timeout(name);
        repeat (3) step();
    endtask

    task automatic set_array(input int a, input logic [AW-1:0] val);
        for (int i = 0; i < TS * TS; i++) mat_in[(a*TS*TS+i)*AW +: AW] = val;
    endtask

    task automatic rand_mat(input bit wide);
        for (int i = 0; i < NA * TS * TS; i++) begin
            mat_in[i*AW +: AW] = wide ? $urandom : AW'($urandom_range(4000) - 2000);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stalled outputs hold.
    initial begin : mon
        exp_t             e;
        logic [TS*OW-1:0] held_vec;
        logic             held_sat;
        bit               holding;
        holding = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 0;
            end else begin
                if (holding) check("hold_stable", {out_vec, sat_flag}, {held_vec, held_sat});
                holding = 0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_out: got %0h expected none", out_vec);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_vec", {out_vec, sat_flag}, {e.vec, e.sat});
                        end
                    end else begin
                        holding  = 1;
                        held_vec = out_vec;
                        held_sat = sat_flag;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_vec", out_vec, '0);
        check("rst_sat_flag", sat_flag, 1'b0);
        check("rst_err_mode", err_mode, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("in_ready_after_reset", in_ready, 1'b1);

        // OUTER, all ones
        for (int a = 0; a < NA; a++) set_array(a, 32'd1);
        send_beat(3'b011, 0);
        drain("outer_ones");

        // MAC over 3 beats; only the last array contributes
        for (int b = 0; b < 3; b++) begin
            rand_mat(1'b1);
            set_array(NA - 1, 32'd2);
            send_beat(3'b000, 3);
        end
        drain("mac_len3");

        // Back-pressure on three OUTER beats
        rdy_mode = 2;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    rand_mat(1'b0);
                    send_beat(3'b011, 0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("in_ready_stalled", in_ready, 1'b0);
                repeat (2) step();
                rdy_mode = 0;
            end
        join
        drain("outer_stall");

        // Out-of-range sums in both directions
        for (int a = 0; a < NA; a++) set_array(a, 32'h0000_4000);
        send_beat(3'b011, 0);
        for (int a = 0; a < NA; a++) set_array(a, 32'hFFFF_C000);
        send_beat(3'b011, 0);
        drain("outer_range");

        // clear aborts a partial MAC tile
        rand_mat(1'b0);
        set_array(NA - 1, 32'd1);
        send_beat(3'b000, 4);
        send_beat(3'b000, 4);
        repeat (4) step();
        clear = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_clear", in_ready, 1'b0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        mac_open = 0;
        for (int b = 0; b < 4; b++) send_beat(3'b000, 4);
        drain("mac_clear");

        // Randomized mix of modes, lengths and back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            rand_mat($urandom_range(7) == 0);
            len = ($urandom_range(19) == 0) ? ML : int'($urandom_range(5));
            case ($urandom_range(9))
                0:       send_beat(3'b101, len);
                1, 2, 3, 4: send_beat(3'b011, len);
                default: send_beat(3'b000, len);
            endcase
            if ($urandom_range(4) == 0) step();
        end
        while (mac_open) begin
            rand_mat(1'b0);
            send_beat(3'b000, 1);
        end
        rdy_mode = 0;
        drain("random");
        check("err_mode_random", err_mode, exp_err);

        // Asynchronous reset in the middle of a MAC tile
        rand_mat(1'b0);
        send_beat(3'b000, 5);
        send_beat(3'b000, 5);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        mac_open = 0;
        exp_err  = 0;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_vec", out_vec, '0);
        check("midrst_err_mode", err_mode, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("in_ready_after_midrst", in_ready, 1'b1);
        send_beat(3'b101, 0);
        repeat (5) step();
        check("err_mode_set", err_mode, 1'b1);
        check("no_out_bad_mode", out_valid, 1'b0);

        // Engine still works after the error
        rand_mat(1'b0);
        send_beat(3'b011, 0);
        drain("outer_after_err");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
